ym_clk_phase_gen: RTL and testbench



---
 rtl/ym_clk_phase_gen_pkg.sv | 30 +++
 rtl/ym_clk_phase_gen_if.sv | 25 ++
 rtl/ym_phase_div.sv | 49 ++++
 rtl/ym_clk_phase_gen.sv | 108 ++++++++++
 tb/tb_ym_clk_phase_gen.sv | 340 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ym_clk_phase_gen_pkg.sv
// Shared timing constants, width helpers, sync-tracking state type and the
// parameter legality check for the two-phase clock generator.
package ym_timing_pkg;

    localparam int YM_DIV      = 6;
    localparam int YM_C1_HI    = 2;
    localparam int YM_C2_START = 3;
    localparam int YM_C2_HI    = 2;
    localparam int YM_SLOTS    = 24;

    localparam int PRESC_W = $clog2(YM_DIV);
    localparam int SLOT_W  = $clog2(YM_SLOTS);

    // ST_RESET marks "no edge seen since reset": the next edge aligns the
    // prescaler to 0 the same way a resync does, so it is not a slot wrap.
    typedef enum logic [1:0] {
        ST_RESET  = 2'd0,
        ST_ALIGN  = 2'd1,
        ST_RUN    = 2'd2,
        ST_LOCKED = 2'd3
    } sync_state_e;

    function automatic bit phase_params_legal(int div, int c1_hi, int c2_start,
                                              int c2_hi, int slots);
        return (div >= 4) && (div <= 16) && (c1_hi >= 1) &&
               (c2_start >= c1_hi + 1) && (c2_hi >= 1) &&
               (c2_start + c2_hi <= div - 1) && (slots >= 2);
    endfunction

endpackage

// File: rtl/ym_clk_phase_gen_if.sv
// Timing bus between the phase generator and the cells it drives:
// resync request in, phase enables and slot position out.
interface ym_clk_phase_gen_if import ym_timing_pkg::*; #(
    parameter int PW = PRESC_W,
    parameter int SW = SLOT_W
);
    logic          ic_sync;
    logic          c1;
    logic          c2;
    logic [PW-1:0] presc;
    logic [SW-1:0] slot;
    logic          slot_strobe;
    logic          frame_start;
    logic          locked;

    modport master (
        input  ic_sync,
        output c1, c2, presc, slot, slot_strobe, frame_start, locked
    );

    modport slave (
        output ic_sync,
        input  c1, c2, presc, slot, slot_strobe, frame_start, locked
    );
endinterface

// File: rtl/ym_phase_div.sv
// MCLK prescaler with registered c1/c2 decode taken from the next count,
// so the phase levels change on the same edge as presc.
module ym_phase_div import ym_timing_pkg::*; #(
    parameter int DIV      = YM_DIV,
    parameter int C1_HI    = YM_C1_HI,
    parameter int C2_START = YM_C2_START,
    parameter int C2_HI    = YM_C2_HI,
    parameter int PW       = $clog2(DIV)
) (
    input  logic          MCLK,
    input  logic          reset,
    input  logic          sync,
    output logic [PW-1:0] presc,
    output logic          c1,
    output logic          c2,
    output logic          wrap_out
);
    localparam logic [PW-1:0] PRESC_MAX = PW'(DIV - 1);
    localparam logic [PW-1:0] C1_END    = PW'(C1_HI);
    localparam logic [PW-1:0] C2_FIRST  = PW'(C2_START);
    localparam logic [PW-1:0] C2_END    = PW'(C2_START + C2_HI);

    logic [PW-1:0] presc_next;

    always_comb begin
        // NOTE: default assignment first keeps this block latch-free.
        presc_next = presc + 1'b1;
        if (sync || (presc == PRESC_MAX)) begin
            presc_next = '0;
        end
    end

    // A resync overrides the natural wrap; it must not count as one.
    assign wrap_out = !sync && (presc == PRESC_MAX);

    always_ff @(posedge MCLK or negedge reset) begin
        if (!reset) begin
            presc <= PRESC_MAX;
            c1    <= 1'b0;
            c2    <= 1'b0;
        end else begin
            // NOTE: non-blocking so each register samples pre-edge values.
            presc <= presc_next;
            c1    <= (presc_next < C1_END);
            c2    <= (presc_next >= C2_FIRST) && (presc_next < C2_END);
        end
    end

endmodule

// File: rtl/ym_clk_phase_gen.sv
// Two-phase clock generator top: prescaler/phase decode plus slot counter,
// first-wrap suppression, frame lock tracking and slot/frame strobes.
module ym_clk_phase_gen import ym_timing_pkg::*; #(
    parameter int DIV      = YM_DIV,
    parameter int C1_HI    = YM_C1_HI,
    parameter int C2_START = YM_C2_START,
    parameter int C2_HI    = YM_C2_HI,
    parameter int SLOTS    = YM_SLOTS
) (
    input  logic                MCLK,
    input  logic                reset,
    ym_clk_phase_gen_if.master  bus
);
    localparam int PW = $clog2(DIV);
    localparam int SW = $clog2(SLOTS);
    localparam logic [SW-1:0] SLOT_MAX = SW'(SLOTS - 1);

    generate
        if (!phase_params_legal(DIV, C1_HI, C2_START, C2_HI, SLOTS)) begin : g_illegal
            $error("ym_clk_phase_gen: illegal DIV/C1_HI/C2_START/C2_HI/SLOTS combination");
        end
    endgenerate

    logic [PW-1:0] presc;
    logic          c1;
    logic          c2;
    logic          wrap;

    ym_phase_div #(
        .DIV      (DIV),
        .C1_HI    (C1_HI),
        .C2_START (C2_START),
        .C2_HI    (C2_HI),
        .PW       (PW)
    ) u_phase_div (
        .MCLK     (MCLK),
        .reset    (reset),
        .sync     (bus.ic_sync),
        .presc    (presc),
        .c1       (c1),
        .c2       (c2),
        .wrap_out (wrap)
    );

    sync_state_e   state;
    sync_state_e   state_next;
    logic [SW-1:0] slot;
    logic          slot_strobe;
    logic          frame_start;
    logic          advance;
    logic          frame_wrap;
    logic          locked;

    always_ff @(posedge MCLK or negedge reset) begin
        if (!reset) begin
            state <= ST_RESET;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (bus.ic_sync) begin
            state_next = ST_ALIGN;
        end else begin
            unique case (state)
                ST_RESET:  state_next = ST_ALIGN;
                ST_ALIGN:  if (wrap) state_next = ST_RUN;
                ST_RUN:    if (wrap && (slot == SLOT_MAX)) state_next = ST_LOCKED;
                ST_LOCKED: state_next = ST_LOCKED;
                default:   state_next = ST_RESET;
            endcase
        end
    end

    // Only wraps after the first one since alignment move the slot.
    always_comb begin
        advance    = wrap && ((state == ST_RUN) || (state == ST_LOCKED));
        frame_wrap = advance && (slot == SLOT_MAX);
        locked     = (state == ST_LOCKED);
    end

    always_ff @(posedge MCLK or negedge reset) begin
        if (!reset) begin
            slot        <= '0;
            slot_strobe <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            slot_strobe <= advance;
            frame_start <= frame_wrap;
            if (bus.ic_sync) begin
                slot <= '0;
            end else if (advance) begin
                slot <= frame_wrap ? '0 : slot + 1'b1;
            end
        end
    end

    assign bus.c1          = c1;
    assign bus.c2          = c2;
    assign bus.presc       = presc;
    assign bus.slot        = slot;
    assign bus.slot_strobe = slot_strobe;
    assign bus.frame_start = frame_start;
    assign bus.locked      = locked;

endmodule

// File: tb/tb_ym_clk_phase_gen.sv
// Bench for ym_clk_phase_gen: table-driven reset release, hand-written
// resync/reset corner cases and random resync against an arithmetic model.
module tb_ym_clk_phase_gen;

    typedef struct {
        logic        c1;
        logic        c2;
        logic [31:0] presc;
        logic [31:0] slot;
        logic        strobe;
        logic        frame;
        logic        locked;
    } exp_t;

    typedef struct {
        logic sync;
        logic c1;
        logic c2;
        int   presc;
        int   slot;
        logic strobe;
    } vec_t;

    logic MCLK;
    logic rst_a;
    logic rst_b;

    int n_checks = 0;
    int n_fail   = 0;

    // Model state: in_rst = no edge since reset; k = edges since alignment.
    bit in_rst_a = 1'b1;
    bit in_rst_b = 1'b1;
    int k_a      = 0;
    int k_b      = 0;

    ym_clk_phase_gen_if #(.PW(3), .SW(5)) bus_a ();
    ym_clk_phase_gen_if #(.PW(3), .SW(5)) bus_b ();

    ym_clk_phase_gen dut_a (
        .MCLK  (MCLK),
        .reset (rst_a),
        .bus   (bus_a)
    );

    ym_clk_phase_gen #(
        .DIV      (8),
        .C1_HI    (3),
        .C2_START (4),
        .C2_HI    (3),
        .SLOTS    (18)
    ) dut_b (
        .MCLK  (MCLK),
        .reset (rst_b),
        .bus   (bus_b)
    );

    initial MCLK = 1'b0;
    always #5 MCLK = ~MCLK;

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Expected outputs from the counting rules: presc = k mod DIV, the first
    // wrap after alignment is swallowed, every later wrap advances the slot.
    function automatic exp_t model(bit ir, int k, int div, int c1h, int c2s,
                                   int c2h, int slots);
        exp_t e;
        int   p;
        int   w;
        int   n;
        if (ir) begin
            e = '{c1: 1'b0, c2: 1'b0, presc: div - 1, slot: 0,
                  strobe: 1'b0, frame: 1'b0, locked: 1'b0};
            return e;
        end
        p        = k % div;
        w        = k / div;
        n        = (w > 0) ? w - 1 : 0;
        e.presc  = p;
        e.c1     = (p < c1h);
        e.c2     = (p >= c2s) && (p < c2s + c2h);
        e.slot   = n % slots;
        e.strobe = (p == 0) && (w >= 2);
        e.frame  = e.strobe && (e.slot == 0);
        e.locked = (n >= slots);
        return e;
    endfunction

    function automatic exp_t exp_a();
        return model(in_rst_a, k_a, 6, 2, 3, 2, 24);
    endfunction

    function automatic exp_t exp_b();
        return model(in_rst_b, k_b, 8, 3, 4, 3, 18);
    endfunction

    function automatic exp_t act_a();
        exp_t a;
        a = '{c1: bus_a.c1, c2: bus_a.c2, presc: 32'(bus_a.presc), slot: 32'(bus_a.slot),
              strobe: bus_a.slot_strobe, frame: bus_a.frame_start, locked: bus_a.locked};
        return a;
    endfunction

    function automatic exp_t act_b();
        exp_t a;
        a = '{c1: bus_b.c1, c2: bus_b.c2, presc: 32'(bus_b.presc), slot: 32'(bus_b.slot),
              strobe: bus_b.slot_strobe, frame: bus_b.frame_start, locked: bus_b.locked};
        return a;
    endfunction

    task automatic cmp(input string tag, input exp_t a, input exp_t e);
        check({tag, ".c1"},          a.c1,     e.c1);
        check({tag, ".c2"},          a.c2,     e.c2);
        check({tag, ".presc"},       a.presc,  e.presc);
        check({tag, ".slot"},        a.slot,   e.slot);
        check({tag, ".slot_strobe"}, a.strobe, e.strobe);
        check({tag, ".frame_start"}, a.frame,  e.frame);
        check({tag, ".locked"},      a.locked, e.locked);
    endtask

    // One MCLK edge: advance both models with the inputs seen at the edge,
    // then sample outputs 1 time unit later.
    task automatic tick();
        @(posedge MCLK);
        if (!rst_a) begin
            in_rst_a = 1'b1;
            k_a      = 0;
        end else if (in_rst_a || bus_a.ic_sync) begin
            in_rst_a = 1'b0;
            k_a      = 0;
        end else begin
            k_a++;
        end
        if (!rst_b) begin
            in_rst_b = 1'b1;
            k_b      = 0;
        end else if (in_rst_b || bus_b.ic_sync) begin
            in_rst_b = 1'b0;
            k_b      = 0;
        end else begin
            k_b++;
        end
        #1;
    endtask

    initial begin
        vec_t vecs[13];
        int   strobe_cnt;
        int   frame_cnt;
        bit   found;
        int   c1_run;
        int   c2_run;
        int   idle_run;
        bit   prev_c1;
        bit   prev_c2;
        bit   seen_c2;
        int   prev_slot;

        vecs = '{
            '{1'b0, 1'b1, 1'b0, 0, 0, 1'b0}, '{1'b0, 1'b1, 1'b0, 1, 0, 1'b0},
            '{1'b0, 1'b0, 1'b0, 2, 0, 1'b0}, '{1'b0, 1'b0, 1'b1, 3, 0, 1'b0},
            '{1'b0, 1'b0, 1'b1, 4, 0, 1'b0}, '{1'b0, 1'b0, 1'b0, 5, 0, 1'b0},
            '{1'b0, 1'b1, 1'b0, 0, 0, 1'b0}, '{1'b0, 1'b1, 1'b0, 1, 0, 1'b0},
            '{1'b0, 1'b0, 1'b0, 2, 0, 1'b0}, '{1'b0, 1'b0, 1'b1, 3, 0, 1'b0},
            '{1'b0, 1'b0, 1'b1, 4, 0, 1'b0}, '{1'b0, 1'b0, 1'b0, 5, 0, 1'b0},
            '{1'b0, 1'b1, 1'b0, 0, 1, 1'b1}
        };

        rst_a         = 1'b0;
        rst_b         = 1'b0;
        bus_a.ic_sync = 1'b0;
        bus_b.ic_sync = 1'b0;

        // Reset state, then release between edges.
        #12;
        cmp("reset_a", act_a(), exp_a());
        cmp("reset_b", act_b(), exp_b());
        rst_a = 1'b1;

        // Reset release, edges 1..13.
        for (int i = 0; i < 13; i++) begin
            bus_a.ic_sync = vecs[i].sync;
            tick();
            check($sformatf("tbl[%0d].c1", i),     bus_a.c1,          vecs[i].c1);
            check($sformatf("tbl[%0d].c2", i),     bus_a.c2,          vecs[i].c2);
            check($sformatf("tbl[%0d].presc", i),  bus_a.presc,       vecs[i].presc);
            check($sformatf("tbl[%0d].slot", i),   bus_a.slot,        vecs[i].slot);
            check($sformatf("tbl[%0d].strobe", i), bus_a.slot_strobe, vecs[i].strobe);
        end

        // Full frame: edges 14..151, slot 1..23 then 0.
        strobe_cnt = 1;
        frame_cnt  = 0;
        for (int i = 14; i <= 151; i++) begin
            tick();
            cmp("frame", act_a(), exp_a());
            if (bus_a.slot_strobe) strobe_cnt++;
            if (bus_a.frame_start) frame_cnt++;
            if (i == 150) check("frame.locked_before_wrap", bus_a.locked, 1'b0);
        end
        check("frame.strobe_count", strobe_cnt, 24);
        check("frame.frame_count", frame_cnt, 1);
        check("frame.end_slot", bus_a.slot, 0);
        check("frame.end_frame_start", bus_a.frame_start, 1'b1);
        check("frame.end_locked", bus_a.locked, 1'b1);

        // Asynchronous reset mid-period while c2 is high and locked.
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            tick();
            found = bus_a.c2;
        end
        check("areset.reach_c2", found, 1'b1);
        check("areset.locked_before", bus_a.locked, 1'b1);
        #4;
        rst_a    = 1'b0;
        in_rst_a = 1'b1;
        k_a      = 0;
        #1;
        check("areset.c1", bus_a.c1, 1'b0);
        check("areset.c2", bus_a.c2, 1'b0);
        check("areset.locked", bus_a.locked, 1'b0);
        check("areset.slot_strobe", bus_a.slot_strobe, 1'b0);
        check("areset.frame_start", bus_a.frame_start, 1'b0);
        check("areset.presc", bus_a.presc, 5);
        check("areset.slot", bus_a.slot, 0);
        rst_a = 1'b1;

        // One-cycle resync at presc=4, slot=10.
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            tick();
            cmp("pre_sync", act_a(), exp_a());
            found = (bus_a.presc == 3'd4) && (bus_a.slot == 5'd10);
        end
        check("sync.reach_p4_s10", found, 1'b1);
        bus_a.ic_sync = 1'b1;
        tick();
        bus_a.ic_sync = 1'b0;
        check("sync.presc", bus_a.presc, 0);
        check("sync.slot", bus_a.slot, 0);
        check("sync.c1", bus_a.c1, 1'b1);
        check("sync.c2", bus_a.c2, 1'b0);
        check("sync.locked", bus_a.locked, 1'b0);
        check("sync.slot_strobe", bus_a.slot_strobe, 1'b0);
        for (int i = 1; i <= 12; i++) begin
            tick();
            cmp("post_sync", act_a(), exp_a());
            if (i == 1) check("post_sync.presc1", bus_a.presc, 1);
            if (i == 6) begin
                check("post_sync.first_wrap_presc", bus_a.presc, 0);
                check("post_sync.first_wrap_no_strobe", bus_a.slot_strobe, 1'b0);
                check("post_sync.first_wrap_slot", bus_a.slot, 0);
            end
            if (i == 12) begin
                check("post_sync.second_wrap_strobe", bus_a.slot_strobe, 1'b1);
                check("post_sync.second_wrap_slot", bus_a.slot, 1);
            end
        end

        // Resync held for 20 cycles freezes everything at count 0.
        bus_a.ic_sync = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            check($sformatf("hold[%0d].c1", i),     bus_a.c1,          1'b1);
            check($sformatf("hold[%0d].c2", i),     bus_a.c2,          1'b0);
            check($sformatf("hold[%0d].presc", i),  bus_a.presc,       0);
            check($sformatf("hold[%0d].slot", i),   bus_a.slot,        0);
            check($sformatf("hold[%0d].strobe", i), bus_a.slot_strobe, 1'b0);
            check($sformatf("hold[%0d].frame", i),  bus_a.frame_start, 1'b0);
        end
        bus_a.ic_sync = 1'b0;

        // Random resync traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            bus_a.ic_sync = ($urandom_range(0, 399) == 0) ||
                            (bus_a.ic_sync && $urandom_range(0, 1) == 1);
            tick();
            cmp("rand_a", act_a(), exp_a());
            check("rand_a.no_overlap", bus_a.c1 & bus_a.c2, 1'b0);
        end
        bus_a.ic_sync = 1'b0;

        // Alternate parameters: DIV=8, 3-cycle phases, 18 slots.
        rst_b     = 1'b1;
        c1_run    = 0;
        c2_run    = 0;
        idle_run  = 0;
        prev_c1   = 1'b0;
        prev_c2   = 1'b0;
        seen_c2   = 1'b0;
        prev_slot = 0;
        for (int i = 0; i < 8 * 18 * 2 + 20; i++) begin
            tick();
            cmp("alt", act_b(), exp_b());
            check("alt.no_overlap", bus_b.c1 & bus_b.c2, 1'b0);
            if (bus_b.c1 && !prev_c1 && seen_c2) check("alt.gap_after_c2", idle_run, 1);
            if (bus_b.c2 && !prev_c2) begin
                check("alt.gap_after_c1", idle_run, 1);
                seen_c2 = 1'b1;
            end
            if (!bus_b.c1 && prev_c1) check("alt.c1_run", c1_run, 3);
            if (!bus_b.c2 && prev_c2) check("alt.c2_run", c2_run, 3);
            if (bus_b.frame_start) begin
                check("alt.wrap_from_slot", prev_slot, 17);
                check("alt.wrap_to_slot", bus_b.slot, 0);
            end
            c1_run    = bus_b.c1 ? c1_run + 1 : 0;
            c2_run    = bus_b.c2 ? c2_run + 1 : 0;
            idle_run  = (bus_b.c1 || bus_b.c2) ? 0 : idle_run + 1;
            prev_c1   = bus_b.c1;
            prev_c2   = bus_b.c2;
            prev_slot = bus_b.slot;
        end
        check("alt.locked_after_frame", bus_b.locked, 1'b1);

        for (int i = 0; i < 1000; i++) begin
            bus_b.ic_sync = ($urandom_range(0, 299) == 0);
            tick();
            cmp("rand_b", act_b(), exp_b());
            check("rand_b.no_overlap", bus_b.c1 & bus_b.c2, 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
